spi_master: RTL and testbench

//  System-clocked SPI master that issues spi_device register frames {w_nr, addr, pad, data}, MSB first.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame layout helpers and master FSM state encoding.
// The frame is {w_nr, addr, zero pad, data}, sent MSB first.
package spi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShift,
      StHold,
      StGap
   } state_e;

   function automatic int unsigned frame_bits(input int unsigned cmd_w, input int unsigned data_w);
      return cmd_w + data_w;
   endfunction

   function automatic int unsigned pad_bits(input int unsigned cmd_w, input int unsigned addr_w);
      return cmd_w - 1 - addr_w;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: o_tick pulses once every CLK_DIV cycles while enabled.
module spi_clk_div #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || !i_en || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master issuing {w_nr, addr, pad, data} register frames; returns read data.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned CMD_WIDTH  = 8,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned GAP_HALVES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_w_nr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  spi_clk,
   output logic                  spi_sel,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);

   localparam int unsigned FRAME_BITS = frame_bits(CMD_WIDTH, DATA_WIDTH);
   localparam int unsigned PAD_BITS   = pad_bits(CMD_WIDTH, ADDR_WIDTH);
   localparam int unsigned BW         = $clog2(FRAME_BITS + 1);
   localparam int unsigned GW         = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP_HALVES - 1);

   state_e                  r_state, w_state_d;
   logic                    r_sclk, w_sclk_d;
   logic                    r_miso, w_miso_d;
   logic [FRAME_BITS-1:0]   r_shift, w_shift_d;
   logic [BW-1:0]           r_bitcnt, w_bitcnt_d;
   logic [GW-1:0]           r_gapcnt, w_gapcnt_d;
   logic                    r_w_nr, w_w_nr_d;
   logic                    r_ready, w_ready_d;
   logic                    r_rsp_valid, w_rsp_valid_d;
   logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_d;
   logic                    w_tick;
   logic                    w_accept;
   logic [CMD_WIDTH-1:0]    w_cmd;

   assign w_accept = cmd_valid && r_ready;
   // Zero pad sits below the address; works for a pad width of zero too.
   assign w_cmd = CMD_WIDTH'({cmd_w_nr, cmd_addr}) << PAD_BITS;

   spi_clk_div #(
      .CLK_DIV(CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (r_state != StIdle),
      .i_clr (w_accept),
      .o_tick(w_tick)
   );

   always_comb begin
      w_state_d     = r_state;
      w_sclk_d      = r_sclk;
      w_miso_d      = r_miso;
      w_shift_d     = r_shift;
      w_bitcnt_d    = r_bitcnt;
      w_gapcnt_d    = r_gapcnt;
      w_w_nr_d      = r_w_nr;
      w_rsp_valid_d = 1'b0;
      w_rdata_d     = r_rdata;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_d  = StSetup;
               w_shift_d  = {w_cmd, cmd_wdata};
               w_w_nr_d   = cmd_w_nr;
               w_bitcnt_d = '0;
               w_gapcnt_d = '0;
               w_sclk_d   = 1'b0;
            end
         end
         StSetup: begin
            if (w_tick) w_state_d = StShift;
         end
         StShift: begin
            if (w_tick) begin
               if (!r_sclk) begin
                  w_sclk_d = 1'b1;
                  w_miso_d = spi_miso;
               end else begin
                  // Falling edge: retire the sampled bit and expose the next MOSI bit.
                  w_sclk_d   = 1'b0;
                  w_shift_d  = {r_shift[FRAME_BITS-2:0], r_miso};
                  w_bitcnt_d = r_bitcnt + 1'b1;
                  if (r_bitcnt == LAST_BIT) w_state_d = StHold;
               end
            end
         end
         StHold: begin
            if (w_tick) begin
               w_state_d     = StGap;
               w_rsp_valid_d = !r_w_nr;
               if (!r_w_nr) w_rdata_d = r_shift[DATA_WIDTH-1:0];
            end
         end
         StGap: begin
            if (w_tick) begin
               if (r_gapcnt == LAST_GAP) w_state_d = StIdle;
               else w_gapcnt_d = r_gapcnt + 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
      w_ready_d = (w_state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_sclk      <= 1'b0;
         r_miso      <= 1'b0;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_gapcnt    <= '0;
         r_w_nr      <= 1'b0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_state     <= w_state_d;
         r_sclk      <= w_sclk_d;
         r_miso      <= w_miso_d;
         r_shift     <= w_shift_d;
         r_bitcnt    <= w_bitcnt_d;
         r_gapcnt    <= w_gapcnt_d;
         r_w_nr      <= w_w_nr_d;
         r_ready     <= w_ready_d;
         r_rsp_valid <= w_rsp_valid_d;
         r_rdata     <= w_rdata_d;
      end
   end

   assign cmd_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign spi_clk   = r_sclk;
   assign spi_sel   = !((r_state == StSetup) || (r_state == StShift) || (r_state == StHold));
   assign spi_mosi  = ((r_state == StSetup) || (r_state == StShift)) && r_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench: SPI slave model plus a cycle-level reference of the master's wire activity.
module tb_spi_master;

   localparam int D = 2, G = 2, CMDW = 8, DW = 8, AW = 3;
   localparam int F = CMDW + DW;
   localparam int LAT = (2 + 2 * F + G) * D;
   localparam int RSP_K = (2 * F + 2) * D;
   localparam int F2 = 8 + 16;
   localparam int LAT2 = (2 + 2 * F2 + 2) * 1;

   logic clk = 1'b0, rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_w_nr = 1'b0, spi_miso = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic cmd_ready, rsp_valid, spi_clk, spi_sel, spi_mosi;
   logic [DW-1:0] rsp_rdata;

   logic c2_valid = 1'b0, c2_miso = 1'b0;
   logic [4:0] c2_addr = 5'h1f;
   logic [15:0] c2_wdata = '0;
   logic c2_ready, c2_rsp_valid, c2_clk, c2_sel, c2_mosi;
   logic [15:0] c2_rdata;

   int n_chk = 0, n_fail = 0, cyc = 0;

   spi_master u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_w_nr(cmd_w_nr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .spi_clk(spi_clk),
      .spi_sel(spi_sel), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   spi_master #(
      .DATA_WIDTH(16), .ADDR_WIDTH(5), .CMD_WIDTH(8), .CLK_DIV(1), .GAP_HALVES(2)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
      .cmd_w_nr(1'b0), .cmd_addr(c2_addr), .cmd_wdata(c2_wdata),
      .rsp_valid(c2_rsp_valid), .rsp_rdata(c2_rdata), .spi_clk(c2_clk),
      .spi_sel(c2_sel), .spi_mosi(c2_mosi), .spi_miso(c2_miso)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end
   initial begin
      #1000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- slave model: register file behind the frame ----------------
   logic [DW-1:0] mem [8] = '{default: 8'h00};
   logic [F-1:0] s_bits = '0, last_frame = '0;
   logic [AW-1:0] s_addr = '0;
   int s_n = 0, last_n = 0, frames = 0, rsp_cnt = 0;

   initial forever begin
      @(negedge spi_sel);
      s_n = 0; s_bits = '0; frames++;
      spi_miso = 1'($urandom);
   end
   initial forever begin
      @(posedge spi_clk);
      if (!spi_sel) begin
         s_bits = {s_bits[F-2:0], spi_mosi};
         s_n++;
         if (s_n == CMDW) s_addr = s_bits[CMDW-2 -: AW];
      end
   end
   initial forever begin
      @(negedge spi_clk);
      if (!spi_sel) begin
         if (s_n >= CMDW && s_n < F) spi_miso = mem[s_addr][DW-1-(s_n-CMDW)];
         else spi_miso = 1'($urandom);
      end
   end
   initial forever begin
      @(posedge spi_sel);
      last_frame = s_bits; last_n = s_n;
      if (s_n == F && s_bits[F-1]) mem[s_addr] = s_bits[DW-1:0];
   end

   // ---------------- reference model: wire activity as a function of time since accept ----------
   logic [DW-1:0] shadow [8] = '{default: 8'h00};
   logic m_ready = 1'b0, m_w = 1'b0;
   logic [AW-1:0] m_a = '0;
   logic [DW-1:0] m_d = '0, m_rdata = '0;
   logic [F-1:0] m_frame = '0;
   int m_k = -1;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_ready = 1'b0; m_k = -1; m_rdata = '0;
      end else if (m_k >= 0) begin
         m_k++;
         if (m_k == RSP_K) begin
            if (m_w) shadow[m_a] = m_d;
            else m_rdata = shadow[m_a];
         end
         if (m_k == LAT) begin m_k = -1; m_ready = 1'b1; end
      end else if (m_ready && cmd_valid) begin
         m_w = cmd_w_nr; m_a = cmd_addr; m_d = cmd_wdata;
         m_frame = F'((32'(cmd_w_nr) << (F - 1)) | (32'(cmd_addr) << (F - 1 - AW)) | 32'(cmd_wdata));
         m_k = 0; m_ready = 1'b0;
      end else begin
         m_ready = 1'b1;
      end
   end

   initial forever begin
      int p, idx;
      logic e_sel, e_clk, e_mosi, e_vld;
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
      if (rst_n) begin
         p = (m_k >= 0) ? m_k / D : 0;
         e_sel = !(m_k >= 0 && p <= 2 * F + 1);
         e_clk = (m_k >= 0) && p >= 2 && p <= 2 * F && (p % 2 == 0);
         e_mosi = 1'b0;
         if (m_k >= 0 && p <= 2 * F) begin
            idx = F - 1 - ((p == 0) ? 0 : (p - 1) / 2);
            e_mosi = m_frame[idx];
         end
         e_vld = (m_k == RSP_K) && !m_w;
         chk("cyc_ready", 32'(cmd_ready), 32'(m_ready));
         chk("cyc_sel", 32'(spi_sel), 32'(e_sel));
         chk("cyc_sclk", 32'(spi_clk), 32'(e_clk));
         chk("cyc_mosi", 32'(spi_mosi), 32'(e_mosi));
         chk("cyc_rsp_valid", 32'(rsp_valid), 32'(e_vld));
         chk("cyc_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      end
   end

   int sel_run = 0, sel_min = 1000;
   initial forever begin
      @(negedge clk);
      if (spi_sel) sel_run++;
      else if (sel_run > 0) begin
         if (sel_run < sel_min) sel_min = sel_run;
         sel_run = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int t_acc);
      logic rdy;
      int n = 0;
      cmd_w_nr = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      do begin
         rdy = cmd_ready;
         @(posedge clk); #1;
         n++;
      end while (!rdy && n < 500);
      if (!rdy) chk("send_timeout", 32'(n), 32'(0));
      t_acc = cyc;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
         if (n >= 500) break;
      end
      if (n >= 500) chk("ready_timeout", 32'(n), 32'(0));
   endtask

   task automatic junk_pulse();
      cmd_valid = 1'b1; cmd_w_nr = 1'b1; cmd_addr = 3'($urandom); cmd_wdata = 8'($urandom);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   initial begin
      int t0, t1, t2, n, fr0, rc0, seen;
      logic [15:0] rd2;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", 32'(spi_sel), 32'(1));
      chk("rst_sclk", 32'(spi_clk), 32'(0));
      chk("rst_mosi", 32'(spi_mosi), 32'(0));
      chk("rst_ready", 32'(cmd_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rdata", 32'(rsp_rdata), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", 32'(cmd_ready), 32'(0));
      @(negedge clk);
      chk("ready_after_edge", 32'(cmd_ready), 32'(1));

      // Write 0x6A to register 7.
      rc0 = rsp_cnt;
      send(1'b1, 3'd7, 8'h6a, t0);
      cmd_valid = 1'b0;
      wait_ready(n);
      chk("wr_latency", 32'(n), 32'(72));
      chk("wr_frame", 32'(last_frame), 32'h0000_f06a);
      chk("wr_sclk_periods", 32'(last_n), 32'(16));
      chk("wr_reg_data", 32'(mem[7]), 32'h6a);
      chk("wr_no_rsp", 32'(rsp_cnt - rc0), 32'(0));

      // Read it back.
      rc0 = rsp_cnt;
      send(1'b0, 3'd7, 8'h00, t0);
      cmd_valid = 1'b0;
      wait_ready(n);
      chk("rd_frame", 32'(last_frame), 32'h0000_7000);
      chk("rd_rsp_count", 32'(rsp_cnt - rc0), 32'(1));
      chk("rd_rdata", 32'(rsp_rdata), 32'h6a);

      // Three back-to-back commands with cmd_valid held.
      sel_run = 0; sel_min = 1000;
      send(1'b1, 3'd5, 8'ha5, t0);
      send(1'b0, 3'd5, 8'h00, t1);
      send(1'b1, 3'd5, 8'h00, t2);
      cmd_valid = 1'b0;
      chk("b2b_period_1", 32'(t1 - t0), 32'(73));
      chk("b2b_period_2", 32'(t2 - t1), 32'(73));
      chk("b2b_rdata", 32'(rsp_rdata), 32'ha5);
      wait_ready(n);
      chk("b2b_sel_gap_ge4", 32'(sel_min >= 4), 32'(1));

      // Requests while busy are ignored.
      fr0 = frames;
      send(1'b1, 3'd3, 8'h11, t0);
      cmd_valid = 1'b0;
      repeat (3) junk_pulse();
      wait_ready(n);
      chk("busy_frames", 32'(frames - fr0), 32'(1));
      chk("busy_reg_data", 32'(mem[3]), 32'h11);

      // Reset in the middle of a write frame.
      send(1'b1, 3'd2, 8'h5c, t0);
      cmd_valid = 1'b0;
      n = 0;
      while (s_n < 7 && n < 500) begin @(negedge clk); n++; end
      chk("abort_reach_edge7", 32'(s_n), 32'(7));
      rst_n = 1'b0;
      #1;
      chk("abort_sel", 32'(spi_sel), 32'(1));
      chk("abort_sclk", 32'(spi_clk), 32'(0));
      chk("abort_ready", 32'(cmd_ready), 32'(0));
      chk("abort_rdata", 32'(rsp_rdata), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_reg_untouched", 32'(mem[2]), 32'(0));
      send(1'b1, 3'd2, 8'h3c, t0);
      cmd_valid = 1'b0;
      wait_ready(n);
      chk("after_abort_frame", 32'(last_frame), 32'h0000_a03c);
      chk("after_abort_reg", 32'(mem[2]), 32'h3c);

      // Randomized traffic; the per-cycle compare carries the checking.
      for (int i = 0; i < 40; i++) begin
         send(1'($urandom), 3'($urandom), 8'($urandom), t0);
         cmd_valid = 1'b0;
         if ($urandom_range(0, 9) < 3) junk_pulse();
         if ($urandom_range(0, 1) == 1) wait_ready(n);
         repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      end
      wait_ready(n);

      // Wide-data instance at CLK_DIV=1 with MISO returning 16'hBEEF.
      c2_valid = 1'b1;
      n = 0;
      while (!c2_ready && n < 500) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      c2_valid = 1'b0;
      n = 0; seen = 0; rd2 = '0;
      forever begin
         @(negedge clk);
         if (c2_rsp_valid) begin seen++; rd2 = c2_rdata; end
         if (c2_ready) break;
         n++;
         if (n >= 500) break;
      end
      chk("w16_latency", 32'(n), 32'(LAT2));
      chk("w16_rsp_count", 32'(seen), 32'(1));
      chk("w16_rdata", 32'(rd2), 32'h0000_beef);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // MISO model for the wide instance: zeros in the command phase, then 16'hBEEF.
   logic [15:0] beef = 16'hbeef;
   int c2_n = 0;
   initial forever begin
      @(negedge c2_sel);
      c2_n = 0; c2_miso = 1'b0;
   end
   initial forever begin
      @(posedge c2_clk);
      if (!c2_sel) c2_n++;
   end
   initial forever begin
      @(negedge c2_clk);
      if (!c2_sel) c2_miso = (c2_n >= 8 && c2_n < F2) ? beef[15-(c2_n-8)] : 1'b0;
   end

endmodule
